// File: rtl/cpu_pkg.sv
// Shared types for the MIPS run controller: run-state encoding and PC width.
package cpu_pkg;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned ST_W  = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_HALT  = 3'd4
    } run_state_t;

endpackage

// File: rtl/definitions.vh
// Core-wide constants shared by the single-cycle MIPS datapath.
// SYSCALL_HALT is the $v0 service code that stops the core.
`ifndef DEFINITIONS_VH
`define DEFINITIONS_VH

`define SYSCALL_HALT 10

`endif

// File: rtl/edge_pulse.sv
// Rising-edge detector for a debounced button level: one registered
// single-cycle pulse per press, however long the button is held.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_pulse
);

    logic r_prev;
    logic r_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= i_level;
            r_pulse <= i_level & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: folds run/step/pause buttons, syscall halt and an optional
// PC breakpoint (macro RUN_CTRL_BP_EN) into the core enable plus counters.
module cpu_run_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_btn,
    input  logic                 step_btn,
    input  logic                 pause_btn,
    input  logic                 halt_in,
    input  logic [PC_W-1:0]      pc_in,
    input  logic [PC_W-1:0]      bp_addr,
    input  logic                 bp_valid,
    output logic                 cpu_en,
    output logic [ST_W-1:0]      state,
    output logic                 bp_stop,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     instr_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic w_run_p;
    logic w_step_p;
    logic w_pause_p;
    logic w_bp_hit;

    run_state_t        r_state;
    run_state_t        w_next_state;
    logic              r_bp_stop;
    logic              w_next_bp_stop;
    logic              w_cpu_en;
    logic [CNT_W-1:0]  r_cycle_count;
    logic [CNT_W-1:0]  r_instr_count;

    edge_pulse u_run_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (run_btn),
        .o_pulse (w_run_p)
    );

    edge_pulse u_step_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (step_btn),
        .o_pulse (w_step_p)
    );

    edge_pulse u_pause_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (pause_btn),
        .o_pulse (w_pause_p)
    );

`ifdef RUN_CTRL_BP_EN
    // Skip suppresses the compare for the first RUN cycle so a resume from
    // the breakpointed PC executes that instruction instead of re-stopping.
    logic r_bp_skip;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bp_skip <= 1'b0;
        end else if ((r_state != ST_RUN) && (w_next_state == ST_RUN)) begin
            r_bp_skip <= 1'b1;
        end else if (r_state == ST_RUN) begin
            r_bp_skip <= 1'b0;
        end
    end

    assign w_bp_hit = bp_valid && (pc_in == bp_addr) && !r_bp_skip;
`else
    logic w_unused_bp;
    assign w_unused_bp = ^{bp_addr, bp_valid, pc_in};
    assign w_bp_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bp_stop <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_bp_stop <= w_next_bp_stop;
        end
    end

    // Next state, bp_stop and the same-cycle enable; pause and breakpoint
    // both kill the enable in the cycle they are seen.
    always_comb begin
        w_next_state   = r_state;
        w_next_bp_stop = r_bp_stop;
        w_cpu_en       = 1'b0;
        case (r_state)
            ST_IDLE, ST_PAUSE: begin
                if (w_run_p) begin
                    w_next_state   = ST_RUN;
                    w_next_bp_stop = 1'b0;
                end else if (w_step_p) begin
                    w_next_state   = ST_STEP;
                    w_next_bp_stop = 1'b0;
                end
            end
            ST_RUN: begin
                if (w_pause_p) begin
                    w_next_state   = ST_PAUSE;
                    w_next_bp_stop = 1'b0;
                end else if (w_bp_hit) begin
                    w_next_state   = ST_PAUSE;
                    w_next_bp_stop = 1'b1;
                end else begin
                    w_cpu_en = 1'b1;
                    if (halt_in) begin
                        w_next_state = ST_HALT;
                    end
                end
            end
            ST_STEP: begin
                w_cpu_en = 1'b1;
                if (halt_in) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state   = ST_PAUSE;
                    w_next_bp_stop = 1'b0;
                end
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state   = ST_IDLE;
                w_next_bp_stop = 1'b0;
            end
        endcase
    end

    // Saturating display counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            if (r_cycle_count != CNT_MAX) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
            if (w_cpu_en && (r_instr_count != CNT_MAX)) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
        end
    end

    assign cpu_en      = w_cpu_en;
    assign state       = ST_W'(r_state);
    assign bp_stop     = r_bp_stop;
    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: per-cycle expectations queued with the
// stimulus schedule and compared at the falling edge.
module tb_cpu_run_ctrl;

`ifdef RUN_CTRL_BP_EN
    localparam bit BP_ON = 1'b1;
`else
    localparam bit BP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_btn = 1'b0;
    logic        step_btn = 1'b0;
    logic        pause_btn = 1'b0;
    logic        halt_in = 1'b0;
    logic [31:0] pc_model;
    logic [31:0] bp_addr = 32'h0;
    logic        bp_valid = 1'b0;
    logic        pc_auto = 1'b1;

    logic        en, en4, bps, bps4;
    logic [2:0]  st, st4;
    logic [31:0] cc, ic;
    logic [3:0]  cc4, ic4;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        int         cyc;
        logic [2:0] st;
        logic       en;
        logic       bps;
        int         ic;
        int         cc;
        int         ic4;
        int         cc4;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // Minimal core stand-in: PC advances by 4 on every enabled cycle.
    always @(posedge clk) begin
        if (rst) pc_model <= 32'h0;
        else if (pc_auto && en) pc_model <= pc_model + 32'd4;
    end

    cpu_run_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run_btn(run_btn), .step_btn(step_btn),
        .pause_btn(pause_btn), .halt_in(halt_in), .pc_in(pc_model),
        .bp_addr(bp_addr), .bp_valid(bp_valid), .cpu_en(en), .state(st),
        .bp_stop(bps), .cycle_count(cc), .instr_count(ic)
    );

    cpu_run_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .run_btn(run_btn), .step_btn(step_btn),
        .pause_btn(pause_btn), .halt_in(halt_in), .pc_in(pc_model),
        .bp_addr(bp_addr), .bp_valid(bp_valid), .cpu_en(en4), .state(st4),
        .bp_stop(bps4), .cycle_count(cc4), .instr_count(ic4)
    );

    task automatic do_reset();
        run_btn = 1'b0; step_btn = 1'b0; pause_btn = 1'b0; halt_in = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        sb.push_back('{"reset_c1", 1, 3'd0, 1'b0, 1'b0, 0, 1, 0, 1});
        sb.push_back('{"reset_c10", 10, 3'd0, 1'b0, 1'b0, 0, 10, 0, 10});
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_checks++;
                if (st !== e.st || en !== e.en || bps !== e.bps ||
                    (e.ic >= 0 && ic !== 32'(e.ic)) || (e.cc >= 0 && cc !== 32'(e.cc)) ||
                    (e.ic4 >= 0 && ic4 !== 4'(e.ic4)) || (e.cc4 >= 0 && cc4 !== 4'(e.cc4))) begin
                    n_errors++;
                    $display("FAIL %s: got st=%0d en=%b bps=%b ic=%0d cc=%0d ic4=%0d cc4=%0d, want st=%0d en=%b bps=%b ic=%0d cc=%0d ic4=%0d cc4=%0d",
                             e.tag, st, en, bps, ic, cc, ic4, cc4, e.st, e.en, e.bps, e.ic, e.cc, e.ic4, e.cc4);
                end
            end
        end
    endtask

    task automatic test_run_pause();
        exp_t e;
        do_reset();
        sb.push_back('{"rp_pulse",   1, 3'd0, 1'b0, 1'b0, 0, 1, -1, -1});
        sb.push_back('{"rp_run",     2, 3'd1, 1'b1, 1'b0, 0, 2, -1, -1});
        sb.push_back('{"rp_run4",    6, 3'd1, 1'b1, 1'b0, 4, -1, -1, -1});
        sb.push_back('{"rp_pausecy", 7, 3'd1, 1'b0, 1'b0, 5, -1, -1, -1});
        sb.push_back('{"rp_paused",  8, 3'd3, 1'b0, 1'b0, 5, 8, -1, -1});
        sb.push_back('{"rp_hold",    9, 3'd3, 1'b0, 1'b0, 5, -1, -1, -1});
        run_btn = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            case (c)
                1: run_btn = 1'b0;
                6: pause_btn = 1'b1;
                8: pause_btn = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_checks++;
                if (st !== e.st || en !== e.en || bps !== e.bps ||
                    (e.ic >= 0 && ic !== 32'(e.ic)) || (e.cc >= 0 && cc !== 32'(e.cc))) begin
                    n_errors++;
                    $display("FAIL %s: got st=%0d en=%b bps=%b ic=%0d cc=%0d, want st=%0d en=%b bps=%b ic=%0d cc=%0d",
                             e.tag, st, en, bps, ic, cc, e.st, e.en, e.bps, e.ic, e.cc);
                end
            end
        end
    endtask

    // Continues from the PAUSE left by test_run_pause (instr_count = 5).
    task automatic test_step();
        exp_t e;
        sb.push_back('{"st_pulse", 1, 3'd3, 1'b0, 1'b0, 5, -1, -1, -1});
        sb.push_back('{"st_step",  2, 3'd2, 1'b1, 1'b0, 5, -1, -1, -1});
        sb.push_back('{"st_back",  3, 3'd3, 1'b0, 1'b0, 6, -1, -1, -1});
        sb.push_back('{"st_held",  8, 3'd3, 1'b0, 1'b0, 6, -1, -1, -1});
        step_btn = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 8) step_btn = 1'b0;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_checks++;
                if (st !== e.st || en !== e.en || bps !== e.bps || ic !== 32'(e.ic)) begin
                    n_errors++;
                    $display("FAIL %s: got st=%0d en=%b bps=%b ic=%0d, want st=%0d en=%b bps=%b ic=%0d",
                             e.tag, st, en, bps, ic, e.st, e.en, e.bps, e.ic);
                end
            end
        end
    endtask

    task automatic test_breakpoint();
        exp_t e;
        bp_valid = 1'b1;
        bp_addr  = 32'h0000_0010;
        pc_auto  = 1'b1;
        do_reset();
        sb.push_back('{"bp_start", 2, 3'd1, 1'b1, 1'b0, 0, -1, -1, -1});
        sb.push_back('{"bp_pc0c",  5, 3'd1, 1'b1, 1'b0, 3, -1, -1, -1});
        sb.push_back('{"bp_pc10",  6, 3'd1, !BP_ON, 1'b0, 4, -1, -1, -1});
        sb.push_back('{"bp_stop",  7, BP_ON ? 3'd3 : 3'd1, !BP_ON, BP_ON, BP_ON ? 4 : 5, -1, -1, -1});
        sb.push_back('{"bp_wait",  8, BP_ON ? 3'd3 : 3'd1, !BP_ON, BP_ON, BP_ON ? 4 : 6, -1, -1, -1});
        sb.push_back('{"bp_resume", 9, 3'd1, 1'b1, 1'b0, BP_ON ? 4 : 7, -1, -1, -1});
        sb.push_back('{"bp_past",  10, 3'd1, 1'b1, 1'b0, BP_ON ? 5 : 8, -1, -1, -1});
        run_btn = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            case (c)
                1: run_btn = 1'b0;
                7: run_btn = 1'b1;
                8: run_btn = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_checks++;
                if (st !== e.st || en !== e.en || bps !== e.bps || ic !== 32'(e.ic)) begin
                    n_errors++;
                    $display("FAIL %s: got st=%0d en=%b bps=%b ic=%0d pc=%h, want st=%0d en=%b bps=%b ic=%0d",
                             e.tag, st, en, bps, ic, pc_model, e.st, e.en, e.bps, e.ic);
                end
            end
        end
        bp_valid = 1'b0;
    endtask

    task automatic test_halt();
        exp_t e;
        do_reset();
        sb.push_back('{"h_sys",    2, 3'd1, 1'b1, 1'b0, 0, -1, -1, -1});
        sb.push_back('{"h_halted", 3, 3'd4, 1'b0, 1'b0, 1, -1, -1, -1});
        sb.push_back('{"h_ignore", 8, 3'd4, 1'b0, 1'b0, 1, -1, -1, -1});
        sb.push_back('{"h_reset", 10, 3'd0, 1'b0, 1'b0, 0, 0, -1, -1});
        run_btn = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            case (c)
                1: run_btn = 1'b0;
                2: halt_in = 1'b1;
                3: begin halt_in = 1'b0; run_btn = 1'b1; step_btn = 1'b1; end
                4: begin run_btn = 1'b0; step_btn = 1'b0; end
                5: step_btn = 1'b1;
                6: step_btn = 1'b0;
                7: pause_btn = 1'b1;
                8: pause_btn = 1'b0;
                9: rst = 1'b1;
                10: rst = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_checks++;
                if (st !== e.st || en !== e.en || bps !== e.bps || ic !== 32'(e.ic) ||
                    (e.cc >= 0 && cc !== 32'(e.cc))) begin
                    n_errors++;
                    $display("FAIL %s: got st=%0d en=%b bps=%b ic=%0d cc=%0d, want st=%0d en=%b bps=%b ic=%0d cc=%0d",
                             e.tag, st, en, bps, ic, cc, e.st, e.en, e.bps, e.ic, e.cc);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        pc_auto  = 1'b0;
        bp_valid = 1'b1;
        bp_addr  = 32'h0;
        do_reset();
        sb.push_back('{"sim_runwins", 2, 3'd1, 1'b1, 1'b0, 0, -1, -1, -1});
        sb.push_back('{"sim_all3",    3, 3'd1, 1'b0, 1'b0, 1, -1, -1, -1});
        sb.push_back('{"sim_paused",  4, 3'd3, 1'b0, 1'b0, 1, -1, -1, -1});
        run_btn  = 1'b1;
        step_btn = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            case (c)
                1: begin run_btn = 1'b0; step_btn = 1'b0; end
                2: pause_btn = 1'b1;
                3: halt_in = 1'b1;
                4: begin pause_btn = 1'b0; halt_in = 1'b0; end
                default: ;
            endcase
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_checks++;
                if (st !== e.st || en !== e.en || bps !== e.bps || ic !== 32'(e.ic)) begin
                    n_errors++;
                    $display("FAIL %s: got st=%0d en=%b bps=%b ic=%0d, want st=%0d en=%b bps=%b ic=%0d",
                             e.tag, st, en, bps, ic, e.st, e.en, e.bps, e.ic);
                end
            end
        end
        bp_valid = 1'b0;
        pc_auto  = 1'b1;
    endtask

    task automatic test_saturation();
        exp_t e;
        do_reset();
        sb.push_back('{"sat_c15", 15, 3'd1, 1'b1, 1'b0, 13, 15, 13, 15});
        sb.push_back('{"sat_c16", 16, 3'd1, 1'b1, 1'b0, 14, 16, 14, 15});
        sb.push_back('{"sat_c25", 25, 3'd1, 1'b1, 1'b0, 23, 25, 15, 15});
        run_btn = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk); #1;
            if (c == 1) run_btn = 1'b0;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_checks++;
                if (st !== e.st || en !== e.en || bps !== e.bps ||
                    ic !== 32'(e.ic) || cc !== 32'(e.cc) ||
                    ic4 !== 4'(e.ic4) || cc4 !== 4'(e.cc4) || st4 !== e.st) begin
                    n_errors++;
                    $display("FAIL %s: got st=%0d en=%b ic=%0d cc=%0d ic4=%0d cc4=%0d, want st=%0d en=%b ic=%0d cc=%0d ic4=%0d cc4=%0d",
                             e.tag, st, en, ic, cc, ic4, cc4, e.st, e.en, e.ic, e.cc, e.ic4, e.cc4);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_pause();
        test_step();
        test_breakpoint();
        test_halt();
        test_simultaneous();
        test_saturation();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: %0d expectations never compared, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller for the single-cycle MIPS core. It turns run, step and pause buttons, the syscall-10 halt and an optional PC breakpoint into one clock-enable, `cpu_en`. That enable gates the core's PC, register-file and RAM write updates. It also keeps saturating cycle and retired-instruction counters for the display path.

## Interface
Parameters:
- `CNT_W`, default 32: width of both counters.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset. One clock; reset is synchronous and active-high.
- `run_btn`, input, 1: run request, level, already debounced.
- `step_btn`, input, 1: single-step request, level.
- `pause_btn`, input, 1: pause request, level.
- `halt_in`, input, 1: the core's combinational halt (syscall with $v0 == 10).
- `pc_in`, input, 32: the core's current PC.
- `bp_addr`, input, 32: breakpoint address.
- `bp_valid`, input, 1: breakpoint armed.
- `cpu_en`, output, 1: core update enable (combinational from state).
- `state`, output, 3: current state encoding.
- `bp_stop`, output, 1: high while paused because of a breakpoint.
- `cycle_count`, output, `CNT_W`: clocks since reset.
- `instr_count`, output, `CNT_W`: cycles with `cpu_en` = 1.

## Operation
- **Button edges.** Each button is registered once; a pulse is one cycle wide and fires on the rising edge only. Holding a button gives exactly one pulse.
- **State encoding.** IDLE=0, RUN=1, STEP=2, PAUSE=3, HALT=4. Unused codes recover to IDLE.
- **`cpu_en`.**
  - 1 in STEP.
  - 1 in RUN when neither `pause_p` nor `bp_hit` is set.
  - 0 otherwise.
- **`bp_hit`.** Set when `bp_valid` is high, `pc_in == bp_addr` and `bp_skip` is 0.
- **`bp_skip`.** Set on every entry into RUN. Cleared after the first RUN cycle. This lets execution resume from the breakpointed PC.
- **IDLE / PAUSE transitions.**
  - `run_p` → RUN.
  - Otherwise `step_p` → STEP.
  - `run_p` and `step_p` together → RUN.
- **RUN transitions, in priority order.**
  1. `pause_p` → PAUSE; `bp_stop` = 0.
  2. `bp_hit` → PAUSE; `bp_stop` = 1. The instruction at `bp_addr` is not executed.
  3. `halt_in` → HALT. The syscall cycle has `cpu_en` = 1.
  4. Otherwise stay in RUN.
- **STEP.** Always exactly one enabled cycle; breakpoints are ignored.
  - `halt_in` → HALT.
  - Otherwise → PAUSE with `bp_stop` = 0.
- **HALT.** Terminal: `cpu_en` = 0 and all buttons are ignored. Only `rst` leaves HALT.
- **`bp_stop`.** Cleared on any exit from PAUSE.
- **`cycle_count`.** +1 every clock while not in reset; saturates at all-ones.
- **`instr_count`.** +1 on every clock with `cpu_en` = 1; saturates at all-ones.

## Timing
- **Reset values:**
  - `state` = IDLE
  - `cpu_en` = 0
  - `bp_stop` = 0
  - `bp_skip` = 0
  - both counters = 0
  - button history registers = 0
- **Button latency.** Button high before edge k → pulse registered at edge k → state changes at edge k+1 → `cpu_en` visible in the cycle after edge k+1.
- **Same-cycle response.** Breakpoint and pause suppress `cpu_en` in the same cycle that the condition is seen. No instruction leaks past either.
- **Reset mid-operation.** `rst` in any state, including HALT or the middle of a STEP, returns to the reset values on that edge. `rst` overrides every other input.
- **Saturation.** A counter at all-ones stays at all-ones; it never wraps to 0.
- **Breakpoint compare.** Full 32-bit equality on `pc_in`; `bp_addr` is not masked.

## Configuration
- `RUN_CTRL_BP_EN` defined: the breakpoint logic is present as described above.
- `RUN_CTRL_BP_EN` undefined:
  - `bp_hit` is tied 0, `bp_skip` is removed and `bp_stop` is constant 0.
  - `bp_addr` and `bp_valid` remain as ports but are ignored.
  - RUN leaves only by pause or halt.

## Structure
- **`cpu_pkg`:** the `run_state_t` enum (3-bit, encodings as above).
- **`definitions.vh`:** the `SYSCALL_HALT` constant (10) lives here alongside the core's existing defines. `cpu_run_ctrl` consumes `halt_in` and does not use it.
- **Sub-module `edge_pulse`:** one instance per button. Registered level in, one-cycle rising-edge pulse out, synchronous reset.
- The FSM, `bp_skip` and both counters live in `cpu_run_ctrl`.

## Test plan
1. **Reset.** Reset, then hold `run_btn` = 0 for 10 cycles → `state` = 0, `cpu_en` = 0, `cycle_count` = 10, `instr_count` = 0.
2. **Run then pause.** Pulse `run_btn` → `cpu_en` = 1 from the second edge onward. After 5 enabled cycles press `pause_btn` → `cpu_en` = 0 in the pulse cycle, `state` = 3, `instr_count` = 5.
3. **Single step.** From PAUSE, hold `step_btn` high for 8 cycles → exactly one enabled cycle, `instr_count` +1, `state` returns to 3.
4. **Breakpoint.** `RUN_CTRL_BP_EN` defined, `bp_valid` = 1, `bp_addr` = 0x0000_0010; run with PC sequencing 0x0, 0x4, … → `cpu_en` = 0 when `pc_in` = 0x10, `bp_stop` = 1, `instr_count` = 4. Run again → PC 0x10 executes, `bp_stop` = 0. Build without the macro → no stop at 0x10.
5. **Halt.** In RUN with `halt_in` = 1 → that cycle `cpu_en` = 1, then `state` = 4. Subsequent run/step presses leave `cpu_en` = 0. Assert `rst` → `state` = 0.
6. **Simultaneous events and saturation.** `run_btn` and `step_btn` rise together in IDLE → `state` = 1. In RUN, `pause_p`, `bp_hit` and `halt_in` together → PAUSE with `bp_stop` = 0. With `CNT_W` = 4, run 20 cycles → both counters hold at 15.
